// File: rtl/y86_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | y86_arb_pkg: shared types and constants for the y86 memory arbiter     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package y86_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;

  localparam logic [31:0] DEF_ERR_RDATA = 32'h0000_0000;

  // A disabled watchdog (TIMEOUT = 0) still needs a one-bit counter to exist.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/y86_arb_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | y86_arb_timer: saturating watchdog counter for stalled memory accesses |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module y86_arb_timer
  import y86_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int              c_width = cnt_width(TIMEOUT);
  localparam logic [c_width-1:0] c_last = c_width'(TIMEOUT - 1);
  localparam logic [c_width-1:0] c_sat  = c_width'(TIMEOUT);

  logic [c_width-1:0] r_wcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wcnt <= '0;
    end else if (clr) begin
      r_wcnt <= '0;
    end else if (en && (r_wcnt != c_sat)) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Fires during the last permitted cycle so the abort lands on the next edge.
  assign expire = (TIMEOUT != 0) && en && (r_wcnt == c_last);

endmodule
`default_nettype wire

// File: rtl/y86_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | y86_mem_arbiter: round-robin core/DMA arbiter for the y86 memory port  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module y86_mem_arbiter
  import y86_arb_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  arb_state_e r_state;
  logic       r_prio;
  logic       r_owner;
  logic       w_win;
  logic       w_expire;
  logic       w_in_access;
  logic       w_finish;

  assign w_in_access = (r_state == ACCESS);
  assign w_finish    = mem_ack || w_expire;

  // Lone requester wins; on contention the master named by r_prio wins.
  always_comb begin
    w_win = m1_req;
    if (m0_req && m1_req) begin
      w_win = r_prio;
    end
  end

  y86_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!w_in_access),
    .en     (w_in_access),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_prio    <= M_CORE;
      r_owner   <= M_CORE;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m0_req || m1_req) begin
            r_state   <= ACCESS;
            r_owner   <= w_win;
            r_prio    <= ~w_win;
            mem_req   <= 1'b1;
            mem_we    <= (w_win == M_DMA) ? m1_we    : m0_we;
            mem_addr  <= (w_win == M_DMA) ? m1_addr  : m0_addr;
            mem_wdata <= (w_win == M_DMA) ? m1_wdata : m0_wdata;
            m0_gnt    <= (w_win == M_CORE);
            m1_gnt    <= (w_win == M_DMA);
          end
        end
        ACCESS: begin
          // An ack in the watchdog's final cycle still completes normally.
          if (w_finish) begin
            r_state <= DONE;
            mem_req <= 1'b0;
            m0_done <= (r_owner == M_CORE);
            m1_done <= (r_owner == M_DMA);
            m0_err  <= !mem_ack && (r_owner == M_CORE);
            m1_err  <= !mem_ack && (r_owner == M_DMA);
            if (!mem_we) begin
              if (r_owner == M_CORE) begin
                m0_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
              end else begin
                m1_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_y86_mem_arbiter: vector table plus scoreboard for y86_mem_arbiter   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_y86_mem_arbiter;
  import y86_arb_pkg::*;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR_RD  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  y86_mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR_RD)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] mdl_rd[2];

  // Memory model: acks the ack_delay+1'th ACCESS cycle, never if ack_delay < 0.
  int          ack_delay = 0;
  logic [31:0] rd_base = '0;
  logic        idle_ack = 1'b0;
  int          acc_cyc = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      acc_cyc = acc_cyc + 1;
      if (acc_cyc == 1) begin
        hold_addr = mem_addr; hold_wdata = mem_wdata; hold_we = mem_we;
      end else begin
        chk("mem_addr_stable", mem_addr, hold_addr);
        chk("mem_wdata_stable", mem_wdata, hold_wdata);
        chk("mem_we_stable", {31'd0, mem_we}, {31'd0, hold_we});
      end
      mem_ack   = (ack_delay >= 0) && (acc_cyc == ack_delay + 1);
      mem_rdata = mem_ack ? (rd_base ^ mem_addr) : 32'hDEAD_BEEF;
    end else begin
      acc_cyc   = 0;
      mem_ack   = idle_ack;
      mem_rdata = 32'h5A5A_5A5A;
    end
  end

  // Scoreboard monitor: grants are checked against the queue head, done pops it.
  always @(negedge clk) begin
    sb_t e;
    if (m0_gnt === 1'b1 || m1_gnt === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      end else begin
        chk("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
        chk("gnt_master", {31'd0, m1_gnt}, {31'd0, sb_q[0].m});
        chk("gnt_mem_req", {31'd0, mem_req}, 32'd1);
        chk("gnt_mem_addr", mem_addr, sb_q[0].addr);
        chk("gnt_mem_we", {31'd0, mem_we}, {31'd0, sb_q[0].we});
        if (sb_q[0].we) chk("gnt_mem_wdata", mem_wdata, sb_q[0].wdata);
      end
    end
    if (m0_done === 1'b1 || m1_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {30'd0, m1_done, m0_done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("done_master", {30'd0, m1_done, m0_done}, e.m ? 32'd2 : 32'd1);
        chk("done_err", {30'd0, m1_err, m0_err}, e.err ? (e.m ? 32'd2 : 32'd1) : 32'd0);
        if (!e.we) mdl_rd[e.m] = e.rdata;
        chk("m0_rdata", m0_rdata, mdl_rd[0]);
        chk("m1_rdata", m1_rdata, mdl_rd[1]);
      end
    end
  end

  task automatic push(input logic m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic err);
    sb_t e;
    e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.err = err;
    e.rdata = err ? ERR_RD : (rd_base ^ addr);
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input logic m, input logic on, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin
      m1_req = on; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = on; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic wait_gnt(input logic m, output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((m ? m1_gnt : m0_gnt) === 1'b1) begin c = cyc; break; end
    end
    if (c < 0) begin
      checks++; failures++;
      $display("FAIL wait_gnt: m%0d got no grant within 50 cycles", m);
    end
  endtask

  task automatic wait_done(input logic m, output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((m ? m1_done : m0_done) === 1'b1) begin c = cyc; break; end
    end
    if (c < 0) begin
      checks++; failures++;
      $display("FAIL wait_done: m%0d saw no done within 50 cycles", m);
    end
  endtask

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdb;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0, cg, cd, prev;
    // m, we, addr, wdata, ack delay (-1 = never), rdata base, err, done cycle
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 0,  32'h1234_5668, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 5, 32'h0, 1'b0, 7};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0050, 32'h0, -1, 32'h0, 1'b1, TIMEOUT + 1};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 2,  32'hA5A5_0000, 1'b0, 4};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0020, 32'h7777_1111, 1, 32'h0, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0090, 32'h0, TIMEOUT - 1, 32'h0BAD_0000, 1'b0, TIMEOUT + 1};
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;

    repeat (2) @(negedge clk);
    chk("reset_ctrl", {24'd0, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_req, mem_we}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_m0_rdata", m0_rdata, 32'd0);
    chk("reset_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ack_delay = vecs[i].dly;
      rd_base   = vecs[i].rdb;
      push(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err);
      c0 = cyc;
      drive_req(vecs[i].m, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      wait_gnt(vecs[i].m, cg);
      chk($sformatf("v%0d_gnt_cycle", i), cg - c0, 1);
      drive_req(vecs[i].m, 1'b0, 1'b0, '0, '0);
      wait_done(vecs[i].m, cd);
      chk($sformatf("v%0d_done_cycle", i), cd - c0, vecs[i].lat);
      @(negedge clk);
      chk($sformatf("v%0d_idle_mem_req", i), {31'd0, mem_req}, 32'd0);
    end

    // Both masters request continuously: strict alternation, 3 cycles apart.
    @(negedge clk);
    ack_delay = 0;
    rd_base   = 32'h1111_0000;
    push(1'b0, 1'b0, 32'h100, '0, 1'b0);
    push(1'b1, 1'b0, 32'h200, '0, 1'b0);
    push(1'b0, 1'b0, 32'h100, '0, 1'b0);
    push(1'b1, 1'b0, 32'h200, '0, 1'b0);
    c0 = cyc;
    drive_req(1'b0, 1'b1, 1'b0, 32'h100, '0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h200, '0);
    prev = c0 - 2;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(k[0], cg);
      chk($sformatf("rr_spacing_%0d", k), cg - prev, (k == 0) ? 3 : 3);
      prev = cg;
    end
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    wait_done(1'b1, cd);
    @(negedge clk);

    // Reset mid-ACCESS drops the access; prio returns to the core.
    ack_delay = -1;
    push(1'b0, 1'b0, 32'h300, '0, 1'b0);
    drive_req(1'b0, 1'b1, 1'b0, 32'h300, '0);
    wait_gnt(1'b0, cg);
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_no_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    ack_delay = 0;
    rd_base   = 32'h2222_0000;
    push(1'b0, 1'b0, 32'h400, '0, 1'b0);
    push(1'b1, 1'b0, 32'h500, '0, 1'b0);
    drive_req(1'b0, 1'b1, 1'b0, 32'h400, '0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h500, '0);
    @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
    wait_gnt(1'b0, cg);
    chk("post_rst_gnt_cycle", cg - c0, 1);
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    wait_gnt(1'b1, cg);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    wait_done(1'b1, cd);
    @(negedge clk);

    // Stray ack while idle must not complete anything or touch rdata.
    idle_ack = 1'b1;
    @(negedge clk);
    idle_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ack_no_done", {29'd0, m1_done, m0_done, mem_req}, 32'd0);
      chk("idle_ack_m0_rdata", m0_rdata, mdl_rd[0]);
      chk("idle_ack_m1_rdata", m1_rdata, mdl_rd[1]);
    end
    rd_base = 32'h3333_0000;
    push(1'b1, 1'b0, 32'h600, '0, 1'b0);
    c0 = cyc;
    drive_req(1'b1, 1'b1, 1'b0, 32'h600, '0);
    wait_gnt(1'b1, cg);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    wait_done(1'b1, cd);
    chk("idle_ack_then_access_latency", cd - c0, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/y86_mem_arbiter.md
# y86_mem_arbiter

Two-master, one-slave memory bus arbiter that shares the single y86 memory port between the processor core (master 0) and a DMA/debug loader (master 1). It sits between the y86 sequencer's bus interface and the memory model. It serialises accesses with round-robin priority and returns per-master completion and read data. A watchdog aborts accesses that memory never acknowledges.

## Interface
- TIMEOUT, 16: ACCESS cycles without `mem_ack` before abort; 0 disables the watchdog.
- ERR_RDATA, 32'h0000_0000: read data returned on an aborted access.
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-low reset.
- m0_req, m1_req  in  1  access request, level, held until `mX_gnt`.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted, inputs latched.
- m0_done, m1_done  out  1  one-cycle pulse: access finished.
- m0_err, m1_err  out  1  valid with done: access aborted by the watchdog.
- m0_rdata, m1_rdata  out  32  read data, valid from done until that master's next done.
- mem_req  out  1  access strobe to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  access complete; read data valid in the same cycle.
- mem_rdata  in  32  memory read data.

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- Requests are sampled only in IDLE.
- IDLE -> ACCESS when any request is present:
  - Single requester wins.
  - If both request, the master named by `prio` wins.
  - The winner's we/addr/wdata are latched into `mem_*`.
  - `prio` is set to the loser.
- ACCESS:
  - `mem_req` is 1; `mem_*` is held stable.
  - `mX_gnt` is 1 for the winner in the first ACCESS cycle only.
  - `wcnt` counts ACCESS cycles.
  - If `mem_ack` = 1, go to DONE. Reads capture `mem_rdata` into the owner's rdata; writes leave rdata unchanged.
  - If `mem_ack` = 0 and TIMEOUT != 0 and `wcnt` = TIMEOUT-1, go to DONE with err. Reads load ERR_RDATA into rdata.
- DONE: `mX_done` (and `mX_err` if aborted) is 1 for one cycle, `mem_req` is 0, next state is IDLE.
- `mem_ack` is ignored in IDLE and DONE.
- A master's req is ignored in ACCESS and DONE. A master whose req is still high in the next IDLE cycle starts a new access.
- Reset (rst = 0 at an edge, any state):
  - State -> IDLE; `prio` = 0 (core first); `wcnt` = 0.
  - All gnt/done/err/mem_req/mem_we = 0.
  - `mem_addr`, `mem_wdata`, m0/m1_rdata = 0.
  - An in-flight access is dropped with no done.

## Timing
- Cycle 0: req high in IDLE.
- Cycle 1: ACCESS, gnt pulse, `mem_req` = 1.
- First cycle with `mem_ack` = 1 (cycle k >= 1): done pulse in cycle k+1; IDLE in cycle k+2.
- Minimum latency is req->done 2 cycles. Minimum spacing between grants is 3 cycles.
- Masters may drop req in the cycle after gnt without causing a duplicate access.
- Watchdog: with no ack, the last ACCESS cycle is cycle TIMEOUT, and done+err occur in cycle TIMEOUT+1.
- `wcnt` width is $clog2(TIMEOUT+1). It is cleared on ACCESS entry and saturates, never wraps.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `y86_arb_pkg` holds:
  - State enum {IDLE, ACCESS, DONE}.
  - Master id constants M_CORE = 0, M_DMA = 1.
  - Default ERR_RDATA.
- One sub-module, `y86_arb_timer`: a watchdog counter with clear/enable inputs and an `expire` output, parameterised by TIMEOUT.
- Arbitration and the FSM stay in the top module.

## Test plan
- Core read, addr 0x0000_0010, ack in cycle 1 with rdata 0x1234_5678 -> m0_gnt in cycle 1; m0_done in cycle 2 with m0_rdata = 0x1234_5678; m0_err = 0.
- Both masters request continuously, ack immediate -> grants alternate m0, m1, m0, m1, 3 cycles apart; mem_addr follows the granted master.
- m1 write, addr 0x40, data 0xCAFE_F00D, ack delayed 5 cycles -> mem_* stable 6 cycles; m1_done one cycle after ack; m1_rdata unchanged.
- m0 read with no ack, TIMEOUT = 16 -> m0_done and m0_err in cycle 17; m0_rdata = ERR_RDATA; IDLE in cycle 18.
- rst = 0 in the middle of ACCESS -> next cycle mem_req = 0 with no done pulse; after release, a simultaneous request is granted to m0.
- mem_ack pulsed while IDLE with no requests -> no done, no rdata change, state stays IDLE.
